// File: rtl/mux_rr_pkg.sv
// Shared constants, FSM state encoding and select decode for the 16:1 round-robin mux scheduler.
package mux_rr_pkg;

   localparam int unsigned N_SRC  = 16;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned HOLD_W = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StGrant = 2'b01,
      StGap   = 2'b10
   } state_e;

   function automatic logic [N_SRC-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
      logic [N_SRC-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin winner search: first set req bit scanning upward from last+1,
// wrapping 15->0.
module rr_pick16
   import mux_rr_pkg::*;
(
   input  logic [N_SRC-1:0] req,
   input  logic [SEL_W-1:0] last,
   output logic [SEL_W-1:0] win,
   output logic             found
);

   logic [SEL_W-1:0] idx;

   always_comb begin
      win   = last;
      found = 1'b0;
      idx   = last;
      // Offset N_SRC wraps to 0, so the previous winner is considered last.
      for (int i = 1; i <= int'(N_SRC); i++) begin
         idx = last + SEL_W'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin grant scheduler for a 16:1 mux: IDLE picks a winner, GRANT holds it for up to
// HOLD_MAX cycles, GAP inserts one dead cycle. All outputs are registered.
module mux_rr_sched
   import mux_rr_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_SRC-1:0] req,
   input  logic             done,
   output logic [SEL_W-1:0] sel,
   output logic [N_SRC-1:0] gnt,
   output logic             valid
);

   state_e            state_q;
   logic [HOLD_W-1:0] hold_q;
   logic [SEL_W-1:0]  last_q;
   logic              armed_q;
   logic [SEL_W-1:0]  pick;
   logic              pick_found;
   logic              grant_end;

   rr_pick16 u_pick (
      .req   (req),
      .last  (last_q),
      .win   (pick),
      .found (pick_found)
   );

   always_comb begin
      grant_end = done | ~req[sel] | (hold_q == HOLD_W'(HOLD_MAX - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sel     <= '0;
         gnt     <= '0;
         valid   <= 1'b0;
         hold_q  <= '0;
         last_q  <= SEL_W'(N_SRC - 1);
         armed_q <= 1'b0;
      end else begin
         // The first edge after reset release only arms the scheduler; arbitration starts next.
         armed_q <= 1'b1;
         case (state_q)
            StIdle: begin
               if (armed_q && en && pick_found) begin
                  state_q <= StGrant;
                  sel     <= pick;
                  gnt     <= sel_onehot(pick);
                  valid   <= 1'b1;
                  hold_q  <= '0;
               end
            end
            StGrant: begin
               if (grant_end) begin
                  state_q <= StGap;
                  gnt     <= '0;
                  valid   <= 1'b0;
                  last_q  <= sel;
                  hold_q  <= '0;
               end else begin
                  hold_q <= hold_q + HOLD_W'(1);
               end
            end
            StGap: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               gnt     <= '0;
               valid   <= 1'b0;
               hold_q  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched: hand-computed grant order, lengths and spacing, plus
// per-cycle output invariants on a HOLD_MAX=4 and a HOLD_MAX=1 instance.
module tb_mux_rr_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        done;
   logic [15:0] req;
   logic [3:0]  sel;
   logic [15:0] gnt;
   logic        valid;
   logic [3:0]  h1_sel;
   logic [15:0] h1_gnt;
   logic        h1_valid;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mux_rr_sched #(.HOLD_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .req   (req),
      .done  (done),
      .sel   (sel),
      .gnt   (gnt),
      .valid (valid)
   );

   mux_rr_sched #(.HOLD_MAX(1)) dut_h1 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .req   (req),
      .done  (done),
      .sel   (h1_sel),
      .gnt   (h1_gnt),
      .valid (h1_valid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Asserts reset mid-cycle, checks the asynchronous clear, then releases one edge later.
   task automatic apply_reset(input logic [15:0] r);
      rst_n = 1'b0;
      #1;
      check("rst_gnt",   32'(gnt),   32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_sel",   32'(sel),   32'h0);
      req = r;
      step();
      rst_n = 1'b1;
   endtask

   // Called with no grant visible; checks idle spacing (if exp_gap >= 0), winner and length.
   task automatic run_grant(input string tag, input logic [3:0] exp_sel, input int exp_len,
                            input int exp_gap);
      int waited = 0;
      int len    = 0;
      while (!valid && waited < 20) begin
         step();
         waited++;
      end
      if (exp_gap >= 0) check($sformatf("%s_gap", tag), 32'(waited), 32'(exp_gap));
      check($sformatf("%s_sel", tag), 32'(sel), 32'(exp_sel));
      while (valid && len < 20) begin
         len++;
         step();
      end
      check($sformatf("%s_len", tag), 32'(len), 32'(exp_len));
   endtask

   always @(negedge clk) begin
      check("onehot",      32'($onehot0(gnt)), 32'd1);
      check("valid_or",    32'(valid),         32'(|gnt));
      check("gnt_sel",     32'(gnt[sel]),      32'(valid));
      check("h1_onehot",   32'($onehot0(h1_gnt)), 32'd1);
      check("h1_valid_or", 32'(h1_valid),      32'(|h1_gnt));
      check("h1_gnt_sel",  32'(h1_gnt[h1_sel]), 32'(h1_valid));
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int len;
      rst_n = 1'b1;
      en    = 1'b0;
      req   = 16'h0000;
      done  = 1'b0;
      #2;

      // Single source, done on the third grant cycle; HOLD_MAX=1 instance grants one cycle.
      en = 1'b1;
      apply_reset(16'h0001);
      step();
      check("rel_edge1_valid", 32'(valid), 32'h0);
      step();
      check("s0_c1_valid", 32'(valid), 32'h1);
      check("s0_c1_gnt",   32'(gnt),   32'h0001);
      check("s0_c1_sel",   32'(sel),   32'h0);
      check("h1_c1_valid", 32'(h1_valid), 32'h1);
      step();
      check("s0_c2_gnt",   32'(gnt),   32'h0001);
      check("h1_c2_valid", 32'(h1_valid), 32'h0);
      step();
      done = 1'b1;
      check("s0_c3_gnt",   32'(gnt),   32'h0001);
      step();
      done = 1'b0;
      check("s0_gap_valid", 32'(valid), 32'h0);
      check("s0_gap_gnt",   32'(gnt),   32'h0);
      check("s0_gap_sel",   32'(sel),   32'h0);
      req = 16'h0000;
      step();
      check("s0_idle_valid", 32'(valid), 32'h0);
      step();
      check("noreq_valid", 32'(valid), 32'h0);

      // All sources requesting: 0..15 then wrap to 0, each 4 cycles, 2 idle cycles apart.
      apply_reset(16'hFFFF);
      for (int k = 0; k < 16; k++) run_grant("ffff", 4'(k), 4, 2);
      run_grant("ffff_wrap", 4'd0, 4, 2);

      // Odd sources only: 1,3,..,15 then wrap to 1.
      apply_reset(16'hAAAA);
      for (int k = 0; k < 8; k++) run_grant("aaaa", 4'(2 * k + 1), 4, 2);
      run_grant("aaaa_wrap", 4'd1, 4, 2);

      // Enable gating: no grant while low; dropping it mid-grant does not truncate.
      en = 1'b0;
      apply_reset(16'h8000);
      repeat (4) begin
         step();
         check("en_low_valid", 32'(valid), 32'h0);
      end
      en = 1'b1;
      step();
      check("en_rise_valid", 32'(valid), 32'h1);
      check("en_rise_sel",   32'(sel),   32'hF);
      en  = 1'b0;
      len = 0;
      while (valid && len < 20) begin
         len++;
         step();
      end
      check("en_drop_len", 32'(len), 32'd4);
      repeat (3) step();
      check("en_off_valid", 32'(valid), 32'h0);
      check("en_off_sel",   32'(sel),   32'hF);

      // Reset during a grant to source 5, then restart from source 0.
      en = 1'b1;
      apply_reset(16'h0020);
      len = 0;
      while (!valid && len < 20) begin
         step();
         len++;
      end
      check("s5_sel", 32'(sel), 32'h5);
      step();
      check("s5_c2_valid", 32'(valid), 32'h1);
      #2;
      apply_reset(16'h0021);
      run_grant("post_rst", 4'd0, 4, 2);
      run_grant("post_rst_next", 4'd5, 4, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
